// File: rtl/pc_redirect_ctrl_pkg.sv
// Shared types and constants for the fetch-redirect controller.
package pc_redirect_ctrl_pkg;

  localparam int unsigned REDIRECT_SRC_W = 2;
  localparam int unsigned FLUSH_CNT_W    = 4;
  localparam int unsigned NUM_SRC        = 4;

  // Redirect targets are at least 4-byte aligned; low two bits are cleared.
  localparam logic [63:0] REDIRECT_ALIGN_MASK = ~64'h3;

  // Encoding doubles as priority: lower value wins.
  typedef enum logic [REDIRECT_SRC_W-1:0] {
    SRC_TRAP = 2'd0,
    SRC_EXU  = 2'd1,
    SRC_DEC  = 2'd2,
    SRC_BPU  = 2'd3
  } redirect_src_e;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PEND  = 2'd1,
    FLUSH = 2'd2
  } state_e;

  // True when source a strictly outranks source b.
  function automatic logic higher_prio(redirect_src_e a, redirect_src_e b);
    return (a < b);
  endfunction

endpackage

// File: rtl/pc_redirect_ctrl_prio_sel.sv
// Combinational 4-way priority select: trap > exu > dec > bpu.
module redirect_prio_sel
  import pc_redirect_ctrl_pkg::*;
#(
  parameter int unsigned MXLEN = 32
) (
  input  logic [NUM_SRC-1:0] req,
  input  logic [MXLEN-1:0]   trap_pc,
  input  logic [MXLEN-1:0]   exu_pc,
  input  logic [MXLEN-1:0]   dec_pc,
  input  logic [MXLEN-1:0]   bpu_pc,
  output logic               win_valid,
  output redirect_src_e      win_src,
  output logic [MXLEN-1:0]   win_pc,
  output logic [NUM_SRC-1:0] lose
);

  // Pick the highest-priority request; every other asserted request loses.
  always_comb begin
    win_valid = 1'b0;
    win_src   = SRC_TRAP;
    win_pc    = '0;
    lose      = '0;
    if (req[0]) begin
      win_valid = 1'b1;
      win_src   = SRC_TRAP;
      win_pc    = trap_pc;
      lose      = req & 4'b1110;
    end else if (req[1]) begin
      win_valid = 1'b1;
      win_src   = SRC_EXU;
      win_pc    = exu_pc;
      lose      = req & 4'b1100;
    end else if (req[2]) begin
      win_valid = 1'b1;
      win_src   = SRC_DEC;
      win_pc    = dec_pc;
      lose      = req & 4'b1000;
    end else if (req[3]) begin
      win_valid = 1'b1;
      win_src   = SRC_BPU;
      win_pc    = bpu_pc;
    end
  end

endmodule

// File: rtl/pc_redirect_ctrl.sv
// Arbitrates fetch-redirect sources into one held redirect for the PC generator,
// then runs a short window that squashes stale BPU predictions.
module pc_redirect_ctrl
  import pc_redirect_ctrl_pkg::*;
#(
  parameter int unsigned MXLEN        = 32,
  parameter int unsigned FLUSH_CYCLES = 2
) (
  input  logic                      i_clk,
  input  logic                      i_rst,
  input  logic [MXLEN-1:0]          i_trap_pc,
  input  logic                      i_trap_valid,
  input  logic [MXLEN-1:0]          i_exu_pc,
  input  logic                      i_exu_valid,
  input  logic [MXLEN-1:0]          i_dec_pc,
  input  logic                      i_dec_valid,
  input  logic [MXLEN-1:0]          i_bpu_pc,
  input  logic                      i_bpu_valid,
  input  logic                      i_stall,
  output logic [MXLEN-1:0]          o_pcRedirect_pcGen_pc,
  output logic                      o_pcRedirect_pcGen_pc_valid,
  output logic                      o_redirect_fire,
  output logic [REDIRECT_SRC_W-1:0] o_flush_src,
  output logic                      o_ifu_flush,
  output logic                      o_bpu_squash,
  output logic                      o_req_drop
);

  localparam logic [FLUSH_CNT_W-1:0] FLUSH_INIT = FLUSH_CNT_W'(FLUSH_CYCLES);
  localparam logic [MXLEN-1:0]       ALIGN_MASK = MXLEN'(REDIRECT_ALIGN_MASK);

  state_e                 state_q, state_d;
  logic [MXLEN-1:0]       pc_q, pc_d;
  redirect_src_e          src_q, src_d;
  logic [FLUSH_CNT_W-1:0] cnt_q, cnt_d;
  logic                   valid_q;
  logic                   drop_held;

  logic                   squash;
  logic                   fire;
  logic [NUM_SRC-1:0]     req;
  logic                   win_valid;
  redirect_src_e          win_src;
  logic [MXLEN-1:0]       win_pc;
  logic [NUM_SRC-1:0]     lose;

  assign squash = (state_q == FLUSH);
  assign fire   = valid_q & ~i_stall;
  // BPU requests never reach the arbiter while the flush window is open.
  assign req    = {i_bpu_valid & ~squash, i_dec_valid, i_exu_valid, i_trap_valid};

  redirect_prio_sel #(.MXLEN(MXLEN)) u_prio_sel (
    .req       (req),
    .trap_pc   (i_trap_pc),
    .exu_pc    (i_exu_pc),
    .dec_pc    (i_dec_pc),
    .bpu_pc    (i_bpu_pc),
    .win_valid (win_valid),
    .win_src   (win_src),
    .win_pc    (win_pc),
    .lose      (lose)
  );

  // State register; a pending redirect is simply discarded on reset.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= IDLE;
      pc_q    <= '0;
      src_q   <= SRC_TRAP;
      cnt_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      src_q   <= src_d;
      cnt_q   <= cnt_d;
      valid_q <= (state_d == PEND);
    end
  end

  // Next-state: accept, hold, replace or drop requests; count down the flush window.
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    src_d     = src_q;
    cnt_d     = cnt_q;
    drop_held = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (win_valid) begin
          pc_d    = win_pc & ALIGN_MASK;
          src_d   = win_src;
          state_d = PEND;
        end
      end
      PEND: begin
        if (!i_stall) begin
          // Anything arriving in the fire cycle is newer than what just left.
          if (win_valid) begin
            pc_d  = win_pc & ALIGN_MASK;
            src_d = win_src;
          end else begin
            state_d = FLUSH;
            cnt_d   = FLUSH_INIT;
          end
        end else if (win_valid) begin
          // Either the held redirect or the newcomer is thrown away.
          drop_held = 1'b1;
          if (higher_prio(win_src, src_q)) begin
            pc_d  = win_pc & ALIGN_MASK;
            src_d = win_src;
          end
        end
      end
      FLUSH: begin
        if (win_valid) begin
          pc_d    = win_pc & ALIGN_MASK;
          src_d   = win_src;
          cnt_d   = '0;
          state_d = PEND;
        end else if (cnt_q <= FLUSH_CNT_W'(1)) begin
          cnt_d   = '0;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - FLUSH_CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign o_pcRedirect_pcGen_pc       = pc_q;
  assign o_pcRedirect_pcGen_pc_valid = valid_q;
  assign o_redirect_fire             = fire;
  assign o_flush_src                 = src_q;
  assign o_ifu_flush                 = fire & (src_q != SRC_BPU);
  assign o_bpu_squash                = squash;
  assign o_req_drop = ~i_rst & ((|lose) | (i_bpu_valid & squash) | drop_held);

endmodule

// File: tb/tb_pc_redirect_ctrl.sv
// Directed bench for pc_redirect_ctrl with an expected-output scoreboard queue.
module tb_pc_redirect_ctrl;

  typedef struct {
    string       tag;
    logic        valid;
    logic [31:0] pc;
    logic [1:0]  src;
    logic        fire;
    logic        ifu;
    logic        sq;
    logic        drop;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] trap_pc, exu_pc, dec_pc, bpu_pc;
  logic        trap_v, exu_v, dec_v, bpu_v, stall;
  logic [31:0] o_pc;
  logic        o_valid, o_fire, o_ifu, o_sq, o_drop;
  logic [1:0]  o_src;

  int   checks = 0;
  int   errors = 0;
  exp_t exp_q[$];

  always #5 clk = ~clk;

  pc_redirect_ctrl #(.MXLEN(32), .FLUSH_CYCLES(2)) dut (
    .i_clk                       (clk),
    .i_rst                       (rst),
    .i_trap_pc                   (trap_pc),
    .i_trap_valid                (trap_v),
    .i_exu_pc                    (exu_pc),
    .i_exu_valid                 (exu_v),
    .i_dec_pc                    (dec_pc),
    .i_dec_valid                 (dec_v),
    .i_bpu_pc                    (bpu_pc),
    .i_bpu_valid                 (bpu_v),
    .i_stall                     (stall),
    .o_pcRedirect_pcGen_pc       (o_pc),
    .o_pcRedirect_pcGen_pc_valid (o_valid),
    .o_redirect_fire             (o_fire),
    .o_flush_src                 (o_src),
    .o_ifu_flush                 (o_ifu),
    .o_bpu_squash                (o_sq),
    .o_req_drop                  (o_drop)
  );

  task automatic cmp(input string tag, input string field,
                     input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s.%s observed=%0h expected=%0h", tag, field, obs, exp);
    end
  endtask

  // Queue this cycle's expectation, compare at the falling edge, then clear request pulses.
  task automatic step(input string tag, input logic v, input logic [31:0] pc,
                      input logic [1:0] src, input logic fire, input logic ifu,
                      input logic sq, input logic drop);
    exp_t e;
    e.tag = tag; e.valid = v; e.pc = pc; e.src = src;
    e.fire = fire; e.ifu = ifu; e.sq = sq; e.drop = drop;
    exp_q.push_back(e);
    @(negedge clk);
    e = exp_q.pop_front();
    cmp(e.tag, "valid", 32'(o_valid), 32'(e.valid));
    cmp(e.tag, "pc",    o_pc,         e.pc);
    cmp(e.tag, "src",   32'(o_src),   32'(e.src));
    cmp(e.tag, "fire",  32'(o_fire),  32'(e.fire));
    cmp(e.tag, "ifu",   32'(o_ifu),   32'(e.ifu));
    cmp(e.tag, "sq",    32'(o_sq),    32'(e.sq));
    cmp(e.tag, "drop",  32'(o_drop),  32'(e.drop));
    @(posedge clk);
    #1;
    trap_v = 1'b0; exu_v = 1'b0; dec_v = 1'b0; bpu_v = 1'b0;
  endtask

  initial begin
    rst = 1'b1; stall = 1'b0;
    trap_v = 1'b0; exu_v = 1'b0; dec_v = 1'b0; bpu_v = 1'b0;
    trap_pc = '0; exu_pc = '0; dec_pc = '0; bpu_pc = '0;
    repeat (2) @(posedge clk);
    #1;
    step("reset", 0, 32'h0, 0, 0, 0, 0, 0);
    rst = 1'b0;

    // Basic exu redirect: one-cycle latency, fire, two-cycle squash window.
    exu_v = 1'b1; exu_pc = 32'h8000_0104;
    step("exu_req",  0, 32'h0,         0, 0, 0, 0, 0);
    step("exu_fire", 1, 32'h8000_0104, 1, 1, 1, 0, 0);
    step("exu_fl1",  0, 32'h8000_0104, 1, 0, 0, 1, 0);
    step("exu_fl2",  0, 32'h8000_0104, 1, 0, 0, 1, 0);
    step("exu_idle", 0, 32'h8000_0104, 1, 0, 0, 0, 0);

    // Dec redirect held through a five-cycle stall.
    stall = 1'b1; dec_v = 1'b1; dec_pc = 32'h200;
    step("dec_req", 0, 32'h8000_0104, 1, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) step("dec_hold", 1, 32'h200, 2, 0, 0, 0, 0);
    stall = 1'b0;
    step("dec_fire", 1, 32'h200, 2, 1, 1, 0, 0);
    step("dec_fl1",  0, 32'h200, 2, 0, 0, 1, 0);
    step("dec_fl2",  0, 32'h200, 2, 0, 0, 1, 0);

    // Trap replaces a held dec; a later exu is dropped.
    stall = 1'b1; dec_v = 1'b1; dec_pc = 32'h200;
    step("rep_req", 0, 32'h200, 2, 0, 0, 0, 0);
    trap_v = 1'b1; trap_pc = 32'h100;
    step("rep_trap", 1, 32'h200, 2, 0, 0, 0, 1);
    exu_v = 1'b1; exu_pc = 32'h300;
    step("rep_exu_drop", 1, 32'h100, 0, 0, 0, 0, 1);
    step("rep_hold", 1, 32'h100, 0, 0, 0, 0, 0);
    stall = 1'b0;
    step("rep_fire", 1, 32'h100, 0, 1, 1, 0, 0);
    step("rep_fl1",  0, 32'h100, 0, 0, 0, 1, 0);
    step("rep_fl2",  0, 32'h100, 0, 0, 0, 1, 0);

    // Simultaneous trap/exu/bpu in IDLE: trap wins, others drop.
    stall = 1'b1;
    trap_v = 1'b1; trap_pc = 32'h100; exu_v = 1'b1; exu_pc = 32'h300;
    bpu_v = 1'b1; bpu_pc = 32'h500;
    step("sim_req", 0, 32'h100, 0, 0, 0, 0, 1);
    step("sim_hold", 1, 32'h100, 0, 0, 0, 0, 0);
    stall = 1'b0;
    step("sim_fire", 1, 32'h100, 0, 1, 1, 0, 0);
    step("sim_fl1",  0, 32'h100, 0, 0, 0, 1, 0);
    step("sim_fl2",  0, 32'h100, 0, 0, 0, 1, 0);

    // BPU squashed during flush window, accepted afterwards.
    exu_v = 1'b1; exu_pc = 32'h700;
    step("sq_req", 0, 32'h100, 0, 0, 0, 0, 0);
    step("sq_fire", 1, 32'h700, 1, 1, 1, 0, 0);
    bpu_v = 1'b1; bpu_pc = 32'h600;
    step("sq_bpu1", 0, 32'h700, 1, 0, 0, 1, 1);
    bpu_v = 1'b1; bpu_pc = 32'h604;
    step("sq_bpu2", 0, 32'h700, 1, 0, 0, 1, 1);
    bpu_v = 1'b1; bpu_pc = 32'h640;
    step("sq_bpu3", 0, 32'h700, 1, 0, 0, 0, 0);

    // Requests in the fire cycle are loaded regardless of priority.
    dec_v = 1'b1; dec_pc = 32'h880;
    step("fc_bpu_fire", 1, 32'h640, 3, 1, 0, 0, 0);
    bpu_v = 1'b1; bpu_pc = 32'h9c0;
    step("fc_dec_fire", 1, 32'h880, 2, 1, 1, 0, 0);
    step("fc_bpu2_fire", 1, 32'h9c0, 3, 1, 0, 0, 0);

    // Non-BPU requests are accepted during the flush window.
    trap_v = 1'b1; trap_pc = 32'h904;
    step("fl_trap", 0, 32'h9c0, 3, 0, 0, 1, 0);
    step("fl_trap_fire", 1, 32'h904, 0, 1, 1, 0, 0);
    exu_v = 1'b1; exu_pc = 32'ha00; bpu_v = 1'b1; bpu_pc = 32'hb00;
    step("fl_exu_bpu", 0, 32'h904, 0, 0, 0, 1, 1);

    // Lower and equal priority requests dropped while held.
    stall = 1'b1; dec_v = 1'b1; dec_pc = 32'hc00;
    step("hold_lower", 1, 32'ha00, 1, 0, 0, 0, 1);
    exu_v = 1'b1; exu_pc = 32'hd00;
    step("hold_equal", 1, 32'ha00, 1, 0, 0, 0, 1);
    stall = 1'b0; exu_v = 1'b1; exu_pc = 32'h400;
    step("pre_rst_fire", 1, 32'ha00, 1, 1, 1, 0, 0);
    stall = 1'b1;
    step("pre_rst_hold", 1, 32'h400, 1, 0, 0, 0, 0);

    // Async reset mid-PEND clears everything before the next edge.
    rst = 1'b1;
    step("rst_async", 0, 32'h0, 0, 0, 0, 0, 0);
    rst = 1'b0; stall = 1'b0;
    for (int i = 0; i < 3; i++) step("post_rst", 0, 32'h0, 0, 0, 0, 0, 0);
    dec_v = 1'b1; dec_pc = 32'h7;
    step("align_req", 0, 32'h0, 0, 0, 0, 0, 0);
    step("align_fire", 1, 32'h4, 2, 1, 1, 0, 0);
    step("align_fl1", 0, 32'h4, 2, 0, 0, 1, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
